// File: rtl/sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sweep_ctrl_pkg
// Shared definitions for the bouncing shift-register sequencer: FSM state
// encoding, length of the register clear phase and the watchdog multiplier.
// -----------------------------------------------------------------------------
package sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Number of cycles the shift register is held in reset before stepping.
    localparam int CLR_CYCLES = 2;

    // Watchdog trips after WDOG_MULT*N steps without a bounce.
    localparam int WDOG_MULT = 2;

    function automatic int wdog_limit(input int n);
        return WDOG_MULT * n;
    endfunction

endpackage

// File: rtl/sweep_prescaler.sv
// -----------------------------------------------------------------------------
// sweep_prescaler
// Step-rate divider. Counts 0..i_div while enabled and produces o_tick in the
// cycle the count equals i_div, then wraps to 0. Holding i_en low freezes the
// count; i_clear forces it back to 0 and has priority.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_clear   : force count to 0
//   i_en      : advance the count this cycle
//   i_div     : terminal count (step every i_div+1 enabled cycles)
//   o_tick    : terminal count reached on an enabled cycle
// -----------------------------------------------------------------------------
module sweep_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_count;

    assign o_tick = i_en && (r_count == i_div);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tick ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/sweep_ctrl.sv
// -----------------------------------------------------------------------------
// sweep_ctrl
// Sequencer for one bouncing one-hot shift register. Clears the register,
// paces it with a programmable step rate, counts bounce periods, completes
// after cfg_periods bounces (or runs until stop when cfg_periods is 0),
// supports hold/abort and flags a stalled register with a step watchdog.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : pulse, begin a sequence (accepted in IDLE only)
//   stop         : pulse, abort to IDLE without done (wins over start)
//   hold         : level, freeze stepping while high
//   cfg_div      : step every cfg_div+1 cycles (latched on start)
//   cfg_periods  : bounce periods to run, 0 = endless (latched on start)
//   period_in    : period_count from the shift register
//   sh_ena       : shift-register step enable, one pulse per step
//   sh_rstn      : shift-register active-low reset
//   busy         : high in CLR, RUN, HOLD
//   done         : one-cycle pulse on completion
//   err          : sticky watchdog flag, cleared by rst or accepted start
//   runs_done    : bounces counted in the current/last sequence
// -----------------------------------------------------------------------------
module sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int N             = 8,
    parameter int COUNTER_WIDTH = 8,
    parameter int DIV_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     hold,
    input  logic [DIV_W-1:0]         cfg_div,
    input  logic [COUNTER_WIDTH-1:0] cfg_periods,
    input  logic [COUNTER_WIDTH-1:0] period_in,
    output logic                     sh_ena,
    output logic                     sh_rstn,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [COUNTER_WIDTH-1:0] runs_done
);

    localparam int WDOG_LIMIT = wdog_limit(N);
    localparam int WD_W       = $clog2(WDOG_LIMIT + 1);
    localparam int CLR_W      = $clog2(CLR_CYCLES + 1);

    state_t                   r_state;
    logic                     r_sh_ena;
    logic                     r_sh_rstn;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;
    logic [COUNTER_WIDTH-1:0] r_runs_done;
    logic [COUNTER_WIDTH-1:0] r_cfg_periods;
    logic [COUNTER_WIDTH-1:0] r_period_q;
    logic [DIV_W-1:0]         r_cfg_div;
    logic [WD_W-1:0]          r_wd;
    logic [CLR_W-1:0]         r_clr_cnt;

    logic                     w_active;
    logic                     w_start_ok;
    logic                     w_tick;
    logic                     w_bounce;
    logic [COUNTER_WIDTH-1:0] w_runs_inc;
    logic                     w_complete;
    logic [WD_W-1:0]          w_wd_next;
    logic                     w_wd_trip;

    assign w_active   = (r_state == ST_RUN) || (r_state == ST_HOLD);
    assign w_start_ok = (r_state == ST_IDLE) && start && !stop;

    // Bounces only count while stepping; the period_count drop caused by the
    // clear phase happens in CLR and is therefore ignored.
    assign w_bounce   = w_active && (period_in != r_period_q);
    assign w_runs_inc = r_runs_done + 1'b1;
    assign w_complete = w_bounce && (r_cfg_periods != '0) && (w_runs_inc == r_cfg_periods);

    // Watchdog counts emitted step pulses; a bounce restarts it.
    assign w_wd_next  = w_bounce ? '0 : r_wd + WD_W'(r_sh_ena);
    assign w_wd_trip  = w_active && (w_wd_next == WD_W'(WDOG_LIMIT));

    // The prescaler also runs on the HOLD cycle where hold has just dropped,
    // so exactly the hold-high cycles are removed from the step spacing.
    sweep_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .i_clear (!w_active || stop),
        .i_en    (w_active && !hold && !stop),
        .i_div   (r_cfg_div),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        r_period_q <= period_in;
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sh_ena      <= 1'b0;
            r_sh_rstn     <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_runs_done   <= '0;
            r_cfg_periods <= '0;
            r_cfg_div     <= '0;
            r_wd          <= '0;
            r_clr_cnt     <= '0;
        end else begin
            r_sh_ena <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state       <= ST_CLR;
                        r_sh_rstn     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_err         <= 1'b0;
                        r_runs_done   <= '0;
                        r_cfg_div     <= cfg_div;
                        r_cfg_periods <= cfg_periods;
                        r_wd          <= '0;
                        r_clr_cnt     <= '0;
                    end
                end
                ST_CLR: begin
                    if (stop) begin
                        r_state   <= ST_IDLE;
                        r_sh_rstn <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (r_clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
                        r_state   <= ST_RUN;
                        r_sh_rstn <= 1'b1;
                        r_wd      <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (w_bounce) begin
                            r_runs_done <= w_runs_inc;
                        end
                        // Completion outranks a watchdog trip on the same cycle.
                        if (w_complete) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (w_wd_trip) begin
                            r_state <= ST_IDLE;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_wd     <= w_wd_next;
                            r_sh_ena <= w_tick;
                            r_state  <= hold ? ST_HOLD : ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_sh_rstn <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign sh_ena    = r_sh_ena;
    assign sh_rstn   = r_sh_rstn;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign runs_done = r_runs_done;

endmodule
